// File: rtl/fft_pkg.sv
// Shared FFT constants, the streamer state encoding and the bit-reverse index helper
// used by both the butterfly stages and the result streamer.
package fft_pkg;

  localparam int FFT_N      = 16;
  localparam int FFT_DATA_W = 16;
  localparam int FFT_ADDR_W = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic logic [FFT_ADDR_W-1:0] bitrev(input logic [FFT_ADDR_W-1:0] idx);
    logic [FFT_ADDR_W-1:0] r;
    r = {FFT_ADDR_W{1'b0}};
    for (int b = 0; b < FFT_ADDR_W; b++) begin
      r[b] = idx[FFT_ADDR_W-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_streamer.sv
// Parallel-in/serial-out FFT result buffer: captures a whole frame in one cycle and
// drains it one word per accepted valid/ready beat, optionally in bit-reversed order.
module fft_result_streamer
  import fft_pkg::*;
#(
  parameter int DATA_W  = FFT_DATA_W,
  parameter int N       = FFT_N,
  parameter int ADDR_W  = FFT_ADDR_W,
  parameter bit BIT_REV = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [N*DATA_W-1:0] din_flat,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                load_err
);

  localparam logic [ADDR_W-1:0] ZERO     = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  // Beat k reads source word map(k); bit reversal restores natural frequency order.
  function automatic logic [ADDR_W-1:0] map_idx(input logic [ADDR_W-1:0] k);
    logic [ADDR_W-1:0] r;
    r = k;
    if (BIT_REV) begin
      for (int b = 0; b < ADDR_W; b++) begin
        r[b] = k[ADDR_W-1-b];
      end
    end else begin
      r = k;
    end
    return r;
  endfunction

  state_t              state, state_next;
  logic [ADDR_W-1:0]   cnt, cnt_next, cnt_inc, rd_idx, first_idx;
  logic [DATA_W-1:0]   buffer [N];
  logic                buf_we;
  logic                valid_next, last_next, busy_next, done_next, err_next;
  logic [DATA_W-1:0]   data_next;
  logic [ADDR_W-1:0]   addr_next;

  assign cnt_inc   = cnt + ONE;
  assign rd_idx    = map_idx(cnt_inc);
  assign first_idx = map_idx(ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next registered-output logic; every output is registered below.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    valid_next = out_valid;
    data_next  = out_data;
    addr_next  = out_addr;
    last_next  = out_last;
    busy_next  = busy;
    done_next  = 1'b0;
    err_next   = 1'b0;
    buf_we     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = STREAM;
          cnt_next   = ZERO;
          buf_we     = 1'b1;
          valid_next = 1'b1;
          busy_next  = 1'b1;
          addr_next  = first_idx;
          data_next  = din_flat[int'(first_idx)*DATA_W +: DATA_W];
          last_next  = (ZERO == LAST_IDX);
        end else begin
          state_next = IDLE;
        end
      end
      STREAM: begin
        err_next = load;
        if (out_valid && out_ready) begin
          if (cnt == LAST_IDX) begin
            state_next = IDLE;
            cnt_next   = ZERO;
            valid_next = 1'b0;
            busy_next  = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            cnt_next  = cnt_inc;
            addr_next = rd_idx;
            data_next = buffer[rd_idx];
            last_next = (cnt_inc == LAST_IDX);
          end
        end else begin
          state_next = STREAM;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = ZERO;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        last_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= ZERO;
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_addr  <= ZERO;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      out_valid <= valid_next;
      out_data  <= data_next;
      out_addr  <= addr_next;
      out_last  <= last_next;
      busy      <= busy_next;
      done      <= done_next;
      load_err  <= err_next;
    end
  end

  // Frame storage needs no reset: contents are only read after a capture.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      for (int i = 0; i < N; i++) begin
        buffer[i] <= din_flat[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Randomized bench for fft_result_streamer: natural-order and bit-reversed instances
// share stimulus and are compared each cycle against a frame/beat-level reference model.
module tb_fft_result_streamer;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic            out_ready;
  logic [N*W-1:0]  din_flat;

  logic            v_n, l_n, b_n, dn_n, e_n;
  logic [W-1:0]    d_n;
  logic [AW-1:0]   a_n;
  logic            v_r, l_r, b_r, dn_r, e_r;
  logic [W-1:0]    d_r;
  logic [AW-1:0]   a_r;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_frame [N];
  bit           m_busy;
  bit           m_done;
  bit           m_err;
  int           m_k;

  always #5 clk = ~clk;

  fft_result_streamer #(.DATA_W(W), .N(N), .ADDR_W(AW), .BIT_REV(1'b0)) u_nat (
    .clk(clk), .rst(rst), .load(load), .din_flat(din_flat), .out_ready(out_ready),
    .out_valid(v_n), .out_data(d_n), .out_addr(a_n), .out_last(l_n),
    .busy(b_n), .done(dn_n), .load_err(e_n)
  );

  fft_result_streamer #(.DATA_W(W), .N(N), .ADDR_W(AW), .BIT_REV(1'b1)) u_rev (
    .clk(clk), .rst(rst), .load(load), .din_flat(din_flat), .out_ready(out_ready),
    .out_valid(v_r), .out_data(d_r), .out_addr(a_r), .out_last(l_r),
    .busy(b_r), .done(dn_r), .load_err(e_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int map_k(input bit rev, input int k);
    int r;
    r = 0;
    if (rev) begin
      for (int b = 0; b < AW; b++) r = r * 2 + ((k >> b) & 1);
    end else begin
      r = k;
    end
    return r;
  endfunction

  task automatic check_one(input bit rev, input logic v, input logic [W-1:0] d,
                           input logic [AW-1:0] a, input logic l, input logic b,
                           input logic dn, input logic e);
    string p;
    p = rev ? "rev" : "nat";
    check({p, ".valid"}, 32'(v), 32'(m_busy));
    check({p, ".busy"},  32'(b), 32'(m_busy));
    check({p, ".done"},  32'(dn), 32'(m_done));
    check({p, ".load_err"}, 32'(e), 32'(m_err));
    check({p, ".last"},  32'(l), 32'(m_busy && m_k == N - 1));
    if (m_busy) begin
      check({p, ".addr"}, 32'(a), 32'(map_k(rev, m_k)));
      check({p, ".data"}, 32'(d), 32'(m_frame[map_k(rev, m_k)]));
    end else if (m_done) begin
      check({p, ".data_hold"}, 32'(d), 32'(m_frame[map_k(rev, N - 1)]));
    end
  endtask

  // One clock: drive at negedge, sample 1 ns after posedge, advance the model.
  task automatic step(input logic ld, input logic rdy, input logic [N*W-1:0] din);
    @(negedge clk);
    load = ld; out_ready = rdy; din_flat = din;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!m_busy) begin
      if (ld) begin
        for (int i = 0; i < N; i++) m_frame[i] = din[i*W +: W];
        m_k = 0;
        m_busy = 1'b1;
      end
    end else begin
      m_err = ld;
      if (rdy) begin
        if (m_k == N - 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_k++;
        end
      end
    end
    check_one(1'b0, v_n, d_n, a_n, l_n, b_n, dn_n, e_n);
    check_one(1'b1, v_r, d_r, a_r, l_r, b_r, dn_r, e_r);
  endtask

  function automatic logic [N*W-1:0] seq_frame(input logic [W-1:0] base, input bit down);
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = down ? W'(base - W'(i)) : W'(base + W'(i));
    return f;
  endfunction

  function automatic logic [N*W-1:0] rand_frame();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = W'($urandom);
    return f;
  endfunction

  task automatic drain(input int mode);
    int g;
    g = 0;
    while (m_busy && g < 100) begin
      step(1'b0, (mode == 0) ? 1'b1 : ((g % 4 == 0) || (g % 4 == 3)), '0);
      g++;
    end
    if (m_busy) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [N*W-1:0] f_a, f_b;
    int g;
    f_a = seq_frame(16'h1000, 1'b0);
    f_b = seq_frame(16'hFFFF, 1'b1);
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_k = 0;
    rst = 1'b1; load = 1'b0; out_ready = 1'b0; din_flat = '0;
    #12;
    check("rst.valid", 32'({v_n, v_r}), 32'd0);
    check("rst.data",  32'({d_n, d_r}), 32'd0);
    check("rst.flags", 32'({b_n, dn_n, e_n, l_n, a_n, b_r, dn_r, e_r, l_r, a_r}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Natural / bit-reversed streaming with ready tied high.
    step(1'b1, 1'b1, f_a);
    drain(0);
    step(1'b0, 1'b1, '0);

    // Ready throttled 1,0,0,1.
    step(1'b1, 1'b0, f_a);
    drain(1);
    step(1'b0, 1'b0, '0);

    // Load during stream, during final accept, then in the done cycle.
    step(1'b1, 1'b1, f_a);
    g = 0;
    while (m_k != 5 && g < 40) begin step(1'b0, 1'b1, '0); g++; end
    step(1'b1, 1'b1, f_b);
    g = 0;
    while (m_k != N - 1 && g < 40) begin step(1'b0, 1'b1, '0); g++; end
    step(1'b1, 1'b1, f_b);
    step(1'b1, 1'b1, f_b);
    check("reload_beat0", 32'(d_n), 32'h0000FFFF);
    drain(0);

    // Asynchronous reset in the middle of beat 7.
    step(1'b1, 1'b1, f_a);
    g = 0;
    while (m_k != 7 && g < 40) begin step(1'b0, 1'b1, '0); g++; end
    #2 rst = 1'b1;
    #1;
    check("arst.valid", 32'({v_n, v_r}), 32'd0);
    check("arst.busy",  32'({b_n, b_r}), 32'd0);
    check("arst.done",  32'({dn_n, dn_r}), 32'd0);
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_k = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, f_b);
    drain(0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 6) == 0, ($urandom % 3) != 0, rand_frame());
    end
    drain(0);
    step(1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
